alu_exec_unit: RTL and testbench

//  Execution stage that consumes the 3-bit ALU operation code produced by the ALU control decoder.

---
 rtl/alu_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : ALU execution stage with valid/ready in/out handshakes. ADD, SUB,
//            AND, OR and SLT complete in one cycle. Shifts (SLL/SRL/SRA) run
//            serially at one bit per cycle when ALU_SHIFT_EN is defined.
//            Otherwise the shift codes are flagged illegal and complete in one
//            cycle with a zero result.
// Config   : `define ALU_SHIFT_EN to build the serial shifter
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic             w_accept;
  logic             w_lt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_illegal;

`ifdef ALU_SHIFT_EN
  localparam int c_SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_shreg;
  logic [c_SHW-1:0] r_cnt;
  logic             r_sh_right;
  logic             r_sh_arith;

  logic [c_SHW-1:0] w_shamt;
  logic             w_start_shift;
  logic [WIDTH-1:0] w_shift_next;

  assign w_shamt = src_b[c_SHW-1:0];
  // Only a shift with a non-zero amount needs the SHIFT state; amount 0 is a
  // plain pass-through of src_a handled by the single-cycle path.
  assign w_start_shift = operation[2] && (operation != 3'b101) && (w_shamt != '0);

  // One-bit step of the serial shifter; SRA replicates the sign bit
  always_comb begin
    w_shift_next = r_shreg;
    if (r_sh_right) begin
      w_shift_next = {r_sh_arith & r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
    end else begin
      w_shift_next = {r_shreg[WIDTH-2:0], 1'b0};
    end
  end
`endif

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_lt     = $signed(src_a) < $signed(src_b);

  // Single-cycle datapath result for the operation presented at accept
  always_comb begin
    w_alu_res     = '0;
    w_alu_illegal = 1'b0;
    case (operation)
      3'b000:  w_alu_res = src_a + src_b;
      3'b001:  w_alu_res = src_a - src_b;
      3'b010:  w_alu_res = src_a & src_b;
      3'b011:  w_alu_res = src_a | src_b;
      3'b101:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: begin
`ifdef ALU_SHIFT_EN
        // Shift by zero: result is src_a unchanged
        w_alu_res     = src_a;
        w_alu_illegal = 1'b0;
`else
        w_alu_res     = '0;
        w_alu_illegal = 1'b1;
`endif
      end
    endcase
  end

  // Control FSM with registered result/zero/illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_SHIFT_EN
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_sh_right <= 1'b0;
      r_sh_arith <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef ALU_SHIFT_EN
            if (w_start_shift) begin
              r_shreg    <= src_a;
              r_cnt      <= w_shamt;
              r_sh_right <= operation[1];
              r_sh_arith <= operation[0];
              r_state    <= S_SHIFT;
            end else begin
`endif
              r_result  <= w_alu_res;
              r_zero    <= (w_alu_res == '0);
              r_illegal <= w_alu_illegal;
              r_state   <= S_DONE;
`ifdef ALU_SHIFT_EN
            end
`endif
          end
        end
`ifdef ALU_SHIFT_EN
        S_SHIFT: begin
          r_shreg <= w_shift_next;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == c_SHW'(1)) begin
            r_result  <= w_shift_next;
            r_zero    <= (w_shift_next == '0);
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Self-checking bench for alu_exec_unit: directed cases followed by
//            randomized operations compared against a behavioural model.
//            Build with ALU_SHIFT_EN defined or not to match the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   operation;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         busy;

  int passes = 0;
  int total  = 0;

  alu_exec_unit #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit is_shift_op(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
  endfunction

  // Behavioural reference: plain arithmetic on the operands
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, output logic ill);
    logic [4:0]          sh;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sh  = b[4:0];
    sa  = a;
    sb  = b;
    ill = 1'b0;
    case (op)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return (sa < sb) ? W'(1) : W'(0);
      default: begin
`ifdef ALU_SHIFT_EN
        if (op == 3'b100) return a << sh;
        if (op == 3'b110) return a >> sh;
        return W'(sa >>> sh);
`else
        ill = 1'b1;
        return '0;
`endif
      end
    endcase
  endfunction

  // Issue one operation, wait for the result, hold it for 'hold' cycles of
  // backpressure (with ignored in_valid pulses), then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic         ei;
    int           expw;
    int           waitc;
    bit           busyok;
    bit           stable;
    er   = model(op, a, b, ei);
    expw = 0;
`ifdef ALU_SHIFT_EN
    if (is_shift_op(op)) expw = int'(b[4:0]);
`endif
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    waitc    = 0;
    busyok   = 1'b1;
    @(negedge clk);
    while (!out_valid && waitc < 100) begin
      busyok &= busy && !in_ready;
      waitc++;
      @(negedge clk);
    end
    check({tag, ".latency"}, waitc, expw);
    if (expw > 0) check({tag, ".busy_in_shift"}, busyok, 1'b1);
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, zero, (er == '0));
    check({tag, ".illegal"}, illegal, ei);
    check({tag, ".in_ready_done"}, {busy, in_ready}, 2'b10);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid  = 1'b1;
        operation = 3'($urandom_range(0, 7));
        src_a     = $urandom;
        src_b     = $urandom;
        @(negedge clk);
        stable &= out_valid && (result === er) && (zero === (er == '0)) && (illegal === ei);
      end
      in_valid = 1'b0;
      check({tag, ".hold_stable"}, stable, 1'b1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, ".after_handshake"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operation = 3'b000;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b0;
    #2;
    check("reset.outputs", {result, zero, illegal, out_valid, busy}, '0);
    check("reset.in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed single-cycle operations
    run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sub",      3'b001, 32'd5, 32'd7, 0);
    run_op("slt_neg",  3'b101, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("slt_pos",  3'b101, 32'h1, 32'hFFFF_FFFF, 0);
    run_op("and",      3'b010, 32'hF0F0, 32'hFF00, 0);
    run_op("or",       3'b011, 32'hF0F0, 32'hFF00, 0);

    // Shift codes: serial shifts or illegal, depending on build
    run_op("sra4",     3'b111, 32'h8000_0000, 32'd4, 0);
    run_op("sll0",     3'b100, 32'h1234_5678, 32'd0, 0);
    run_op("srl31",    3'b110, 32'h8000_0000, 32'd31, 0);

    // Backpressure with ignored input pulses
    run_op("hold_add", 3'b000, 32'd2, 32'd3, 5);

    // Asynchronous reset with an operation in flight
    @(negedge clk);
    in_valid = 1'b1;
    src_a    = 32'h8000_0000;
    src_b    = 32'd20;
`ifdef ALU_SHIFT_EN
    operation = 3'b110;
`else
    operation = 3'b000;
    src_b     = 32'd7;
`endif
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.outputs", {result, zero, illegal, out_valid, busy}, '0);
    check("midreset.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_op("post_reset_add", 3'b000, 32'd1, 32'd1, 0);

    run_op("code110", 3'b110, 32'h1234, 32'd3, 0);
    run_op("add_after_110", 3'b000, 32'd10, 32'd20, 0);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 5 == 0) ra = 32'h8000_0000 | ra;
      if (n % 7 == 0) rb = ra;
      run_op($sformatf("rand%0d", n), rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
